mat_key_emu: RTL and testbench

Matrix-keypad emulator: the responder side of the 4x4 row-scan keypad interface used in the music design. It takes queued key-press commands (key code plus hold time) and drives the column lines in response to the row strobes, exactly as a physical keypad would. A scanner can be exercised without hardware, and scripted note sequences (demo/autoplay) can be injected through the same path as real key presses.

---
 rtl/mat_key_emu.sv | 126 ++++++++++++
 tb/tb_mat_key_emu.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mat_key_emu.sv
// Matrix-keypad emulator: queues {key, hold} commands and answers row strobes
// on the column lines as a physical 4x4 keypad would.
module mat_key_emu #(
    parameter int FIFO_DEPTH = 4,
    parameter int HOLD_W     = 16,
    parameter int GAP_CYCLES = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [3:0]                        row,
    output logic [3:0]                        col,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [3:0]                        cmd_key,
    input  logic [HOLD_W-1:0]                 cmd_hold,
    input  logic                              flush,
    output logic                              pressed,
    output logic [3:0]                        cur_key,
    output logic                              done,
    output logic [$clog2(FIFO_DEPTH):0]       level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

    logic [3:0]        key_mem  [FIFO_DEPTH];
    logic [HOLD_W-1:0] hold_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              push, pop;

    state_t            state, state_n;
    logic [HOLD_W-1:0] cnt, cnt_n;
    logic              pressed_n, done_n;
    logic [3:0]        cur_key_n;
    logic [HOLD_W-1:0] head_hold;

    // A full queue refuses pushes even when a pop happens in the same cycle.
    assign push      = cmd_valid && cmd_ready && !flush;
    assign head_hold = hold_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            key_mem[wr_ptr]  <= cmd_key;
            hold_mem[wr_ptr] <= cmd_hold;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + LW'(1);
            else if (pop && !push) level <= level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            pressed <= 1'b0;
            cur_key <= 4'd0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            pressed <= pressed_n;
            cur_key <= cur_key_n;
            done    <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        pressed_n = pressed;
        cur_key_n = cur_key;
        done_n    = 1'b0;
        pop       = 1'b0;
        if (flush) begin
            state_n   = IDLE;
            cnt_n     = '0;
            pressed_n = 1'b0;
            cur_key_n = 4'd0;
        end else begin
            case (state)
                IDLE: if (level != '0) begin
                    pop       = 1'b1;
                    state_n   = PRESS;
                    pressed_n = 1'b1;
                    cur_key_n = key_mem[rd_ptr];
                    // Hold 0 behaves as hold 1.
                    cnt_n     = (head_hold == '0) ? '0 : head_hold - 1'b1;
                end
                PRESS: if (cnt == '0) begin
                    state_n   = GAP;
                    pressed_n = 1'b0;
                    cur_key_n = 4'd0;
                    cnt_n     = HOLD_W'(GAP_CYCLES - 1);
                end else begin
                    cnt_n = cnt - 1'b1;
                end
                GAP: if (cnt == '0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Column return is a zero-cycle path from the row strobes.
    always_comb begin
        cmd_ready = (level != LW'(FIFO_DEPTH));
        col       = 4'hF;
        if (pressed && !row[cur_key[3:2]])
            col[cur_key[1:0]] = 1'b0;
    end
endmodule

// File: tb/tb_mat_key_emu.sv
// Bench for mat_key_emu: schedule-based reference model plus directed literal checks.
module tb_mat_key_emu;
    localparam int DEPTH = 4;
    localparam int HW    = 16;
    localparam int G     = 16;

    logic          clk = 1'b0, rst = 1'b1;
    logic [3:0]    row = 4'hF, col;
    logic          cmd_valid = 1'b0, cmd_ready;
    logic [3:0]    cmd_key = 4'd0, cur_key;
    logic [HW-1:0] cmd_hold = '0;
    logic          flush = 1'b0, pressed, done;
    logic [2:0]    level;

    mat_key_emu #(.FIFO_DEPTH(DEPTH), .HOLD_W(HW), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst(rst), .row(row), .col(col),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key),
        .cmd_hold(cmd_hold), .flush(flush), .pressed(pressed),
        .cur_key(cur_key), .done(done), .level(level)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    typedef struct { logic [3:0] key; int hold; } cmd_t;
    cmd_t   q[$];
    longint e = 0, s = 0;
    int     hp = 1;
    bit     busy = 0, m_done = 0, m_pressed = 0, chk_en = 0;
    logic [3:0] mkey = 4'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h (edge %0d)", name, act, exp, e);
        end
    endtask

    // The model tracks each press as a time window [s, s+hp) with done at s+hp+G.
    task automatic model_update();
        bit   full_pre;
        cmd_t c;
        e++;
        full_pre = (q.size() >= DEPTH);
        m_done   = 0;
        if (rst || flush) begin
            q.delete();
            busy = 0;
        end else begin
            if (!busy && q.size() > 0) begin
                c    = q.pop_front();
                busy = 1;
                s    = e;
                hp   = (c.hold == 0) ? 1 : c.hold;
                mkey = c.key;
            end else if (busy && e == s + hp + G) begin
                busy   = 0;
                m_done = 1;
            end
            if (cmd_valid && !full_pre) q.push_back('{cmd_key, int'(cmd_hold)});
        end
        m_pressed = busy && (e < s + hp);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin : compare
        logic [3:0] ec;
        logic [3:0] ek;
        int r, c;
        if (chk_en) begin
            ec = 4'hF;
            ek = 4'd0;
            if (m_pressed) begin
                r  = int'(mkey) / 4;
                c  = int'(mkey) % 4;
                ek = mkey;
                if (row[r] == 1'b0) ec[c] = 1'b0;
            end
            chk("pressed", pressed, m_pressed);
            chk("cur_key", cur_key, ek);
            chk("done", done, m_done);
            chk("level", level, q.size());
            chk("cmd_ready", cmd_ready, q.size() < DEPTH);
            chk("col", col, ec);
        end
    end

    int np, nd, k, n, dedge;
    logic rdy;

    initial begin
        repeat (3) cycle();
        rst    = 1'b0;
        chk_en = 1;

        for (int i = 0; i < 4; i++) begin
            row = ~(4'b0001 << i);
            cycle();
            chk("rst_col", col, 4'hF);
            chk("rst_ready", cmd_ready, 1);
            chk("rst_level", level, 0);
        end

        // key 6, hold 5
        row = 4'hE; cmd_valid = 1'b1; cmd_key = 4'd6; cmd_hold = 16'd5;
        cycle();
        n = int'(e); cmd_valid = 1'b0; np = 0; dedge = -1;
        for (int i = 0; i < 30; i++) begin
            row = ~(4'b0001 << (i % 4));
            cycle();
            if (pressed) np++;
            if (done) dedge = int'(e);
            if (pressed && row == 4'b1101) chk("k6_col", col, 4'b1011);
        end
        chk("k6_press_len", np, 5);
        chk("k6_done_edge", dedge - n, 22);

        // hold 0, key 9, row 0000
        row = 4'h0; cmd_valid = 1'b1; cmd_key = 4'd9; cmd_hold = '0;
        cycle();
        cmd_valid = 1'b0;
        cycle();
        chk("row0_col", col, 4'b1101);
        np = pressed ? 1 : 0;
        repeat (25) begin cycle(); if (pressed) np++; end
        chk("hold0_len", np, 1);

        // five back-to-back commands, queue fills
        cmd_valid = 1'b1; cmd_hold = 16'd30; k = 0; nd = 0;
        for (int i = 0; i < 50 && k < 5; i++) begin
            cmd_key = 4'(k * 3);
            row = 4'($urandom);
            rdy = cmd_ready;
            cycle();
            if (rdy) k++;
            if (done) nd++;
        end
        cmd_valid = 1'b0;
        chk("b2b_accepted", k, 5);
        chk("full_ready", cmd_ready, 0);
        repeat (300) begin row = 4'($urandom); cycle(); if (done) nd++; end
        chk("b2b_done", nd, 5);

        // abort mid-press: pass 0 uses flush, pass 1 uses rst
        for (int p = 0; p < 2; p++) begin
            cmd_valid = 1'b1; cmd_hold = 16'd50; cmd_key = 4'd5; row = 4'h0;
            repeat (3) cycle();
            cmd_valid = 1'b0;
            repeat (5) cycle();
            chk("abort_pre_pressed", pressed, 1);
            cmd_valid = 1'b1;
            if (p == 0) flush = 1'b1; else rst = 1'b1;
            cycle();
            flush = 1'b0; rst = 1'b0; cmd_valid = 1'b0;
            chk("abort_pressed", pressed, 0);
            chk("abort_level", level, 0);
            chk("abort_col", col, 4'hF);
            nd = 0;
            repeat (80) begin cycle(); if (done) nd++; end
            chk("abort_no_done", nd, 0);
        end

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cmd_valid = ($urandom % 3 == 0);
            cmd_key   = 4'($urandom);
            cmd_hold  = ($urandom % 8 == 0) ? HW'($urandom % 40) : HW'($urandom % 6);
            row       = 4'($urandom);
            flush     = ($urandom % 300 == 0);
            rst       = ($urandom % 500 == 0);
            cycle();
        end
        flush = 1'b0; rst = 1'b0; cmd_valid = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
